// File: rtl/code_line_decoder_if.sv
// Code-stream handshake: producer offers 2-bit priority codes, decoder returns ready.
interface code_line_decoder_if;
  logic       code_valid;
  logic [1:0] code;
  logic       code_ready;

  modport master (
    output code_valid,
    output code,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    output code_ready
  );
endinterface

// File: rtl/code_line_decoder.sv
// Priority-code line decoder: buffers 2-bit codes in a FIFO and replays each one as a
// one-hot assertion on a/b/c held for HOLD cycles. Code 00 replays as an all-low slot.
module code_line_decoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  code_line_decoder_if.slave       cif,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     active,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(HOLD) + 1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic            c_q, c_d;

  logic            push;
  logic            pop;
  logic            have_code;
  logic [1:0]      head;

  assign cif.code_ready = (level_q != LW'(DEPTH));
  assign push           = cif.code_valid && cif.code_ready;
  // Pop decisions use the registered level, so a word is never popped on its push edge.
  assign have_code      = (level_q != '0);
  assign head           = mem_q[rptr_q];

  // Next-state: FSM, hold counter, decoded lines and FIFO bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    mem_d   = mem_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (have_code) begin
          pop = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (have_code) begin
          pop = 1'b1;
        end else begin
          state_d = StIdle;
          a_d     = 1'b0;
          b_d     = 1'b0;
          c_d     = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (pop) begin
      state_d = StHold;
      cnt_d   = CW'(HOLD - 1);
      rptr_d  = rptr_q + 1'b1;
      a_d     = (head == 2'b11);
      b_d     = (head == 2'b10);
      c_d     = (head == 2'b01);
    end

    if (push) begin
      mem_d[wptr_q] = cif.code;
      wptr_d        = wptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state with asynchronous clear; reset drops all queued and in-flight codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a      = a_q;
  assign b      = b_q;
  assign c      = c_q;
  assign active = (state_q == StHold);
  assign busy   = active || (level_q != '0);
  assign level  = level_q;

endmodule

// File: tb/tb_code_line_decoder.sv
// Directed bench: table-driven single/back-to-back/gap sequences, then hand-written
// full-FIFO, HOLD=1 wrap and asynchronous reset sequences.
module tb_code_line_decoder;

  logic       clk;
  logic       rst_n;
  logic       a0, b0, c0, act0, busy0;
  logic [2:0] lvl0;
  logic       a1, b1, c1, act1, busy1;
  logic [2:0] lvl1;

  int tests = 0;
  int fails = 0;

  code_line_decoder_if cif0 ();
  code_line_decoder_if cif1 ();

  code_line_decoder #(.DEPTH(4), .HOLD(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cif    (cif0),
    .a      (a0),
    .b      (b0),
    .c      (c0),
    .active (act0),
    .busy   (busy0),
    .level  (lvl0)
  );

  code_line_decoder #(.DEPTH(4), .HOLD(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cif    (cif1),
    .a      (a1),
    .b      (b1),
    .c      (c1),
    .active (act1),
    .busy   (busy1),
    .level  (lvl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic [2:0] abc;
    logic       act;
    logic       busy;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] cd, input logic [2:0] abc,
                     input logic act, input logic bsy, input logic [2:0] lvl, input logic rdy);
    vec_t r;
    r.v = v; r.code = cd; r.abc = abc; r.act = act; r.busy = bsy; r.lvl = lvl; r.rdy = rdy;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] dec(input logic [1:0] cd);
    case (cd)
      2'b11:   dec = 3'b100;
      2'b10:   dec = 3'b010;
      2'b01:   dec = 3'b001;
      default: dec = 3'b000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] burst   [8]  = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
  logic [1:0] accepted[6]  = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
  logic [2:0] burst_lvl[8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3};
  logic [1:0] stream  [10] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10,
                               2'b01, 2'b11, 2'b10, 2'b01, 2'b11};

  initial begin
    logic [2:0] exp_abc;
    logic       exp_act;

    cif0.code_valid = 1'b0;
    cif0.code       = 2'b00;
    cif1.code_valid = 1'b0;
    cif1.code       = 2'b00;
    rst_n           = 1'b0;

    // Single code 11
    add(1, 2'b11, 3'b000, 0, 1, 3'd1, 1);
    add(0, 2'b00, 3'b100, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b100, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b100, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 3'd0, 1);
    // Back-to-back 11,10,01
    add(1, 2'b11, 3'b000, 0, 1, 3'd1, 1);
    add(1, 2'b10, 3'b100, 1, 1, 3'd1, 1);
    add(1, 2'b01, 3'b100, 1, 1, 3'd2, 1);
    add(0, 2'b00, 3'b100, 1, 1, 3'd2, 1);
    add(0, 2'b00, 3'b010, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b010, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b010, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 3'd0, 1);
    // Gap code 10,00,01
    add(1, 2'b10, 3'b000, 0, 1, 3'd1, 1);
    add(1, 2'b00, 3'b010, 1, 1, 3'd1, 1);
    add(1, 2'b01, 3'b010, 1, 1, 3'd2, 1);
    add(0, 2'b00, 3'b010, 1, 1, 3'd2, 1);
    add(0, 2'b00, 3'b000, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b000, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b000, 1, 1, 3'd1, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b001, 1, 1, 3'd0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 3'd0, 1);

    // Values while held in reset
    #3;
    chk("rst_abc",   {a0, b0, c0}, 3'b000);
    chk("rst_act",   act0, 1'b0);
    chk("rst_busy",  busy0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    chk("rst_ready", cif0.code_ready, 1'b1);
    #9 rst_n = 1'b1;
    step();

    // Table-driven sequences
    for (int i = 0; i < tbl.size(); i++) begin
      cif0.code_valid = tbl[i].v;
      cif0.code       = tbl[i].code;
      step();
      chk($sformatf("tbl%0d_abc", i),   {a0, b0, c0}, tbl[i].abc);
      chk($sformatf("tbl%0d_act", i),   act0, tbl[i].act);
      chk($sformatf("tbl%0d_busy", i),  busy0, tbl[i].busy);
      chk($sformatf("tbl%0d_level", i), lvl0, tbl[i].lvl);
      chk($sformatf("tbl%0d_ready", i), cif0.code_ready, tbl[i].rdy);
    end
    cif0.code_valid = 1'b0;

    // Full FIFO: 8 offered, 6 accepted (pops at edges 2 and 5 free slots), 2 dropped
    for (int n = 1; n <= 20; n++) begin
      cif0.code_valid = (n <= 8);
      cif0.code       = (n <= 8) ? burst[n-1] : 2'b00;
      step();
      if (n >= 2 && n <= 19) begin
        exp_abc = dec(accepted[(n-2)/3]);
        exp_act = 1'b1;
      end else begin
        exp_abc = 3'b000;
        exp_act = 1'b0;
      end
      chk($sformatf("full%0d_abc", n), {a0, b0, c0}, exp_abc);
      chk($sformatf("full%0d_act", n), act0, exp_act);
      chk($sformatf("full%0d_onehot", n), $countones({a0, b0, c0}) <= 1, 1'b1);
      if (n <= 8) begin
        chk($sformatf("full%0d_level", n), lvl0, burst_lvl[n-1]);
        chk($sformatf("full%0d_ready", n), cif0.code_ready, burst_lvl[n-1] != 3'd4);
      end
    end
    chk("full_end_busy",  busy0, 1'b0);
    chk("full_end_level", lvl0, 3'd0);

    // HOLD=1: continuous stream across pointer wrap, one code per cycle
    for (int n = 1; n <= 12; n++) begin
      cif1.code_valid = (n <= 10);
      cif1.code       = (n <= 10) ? stream[n-1] : 2'b00;
      step();
      exp_abc = (n >= 2 && n <= 11) ? dec(stream[n-2]) : 3'b000;
      chk($sformatf("h1_%0d_abc", n),   {a1, b1, c1}, exp_abc);
      chk($sformatf("h1_%0d_act", n),   act1, (n >= 2 && n <= 11));
      chk($sformatf("h1_%0d_level", n), lvl1, (n <= 10) ? 3'd1 : 3'd0);
    end
    cif1.code_valid = 1'b0;

    // Asynchronous reset mid-hold with a queued code
    cif0.code_valid = 1'b1;
    cif0.code       = 2'b11;
    step();
    cif0.code       = 2'b10;
    step();
    cif0.code_valid = 1'b0;
    chk("pre_rst_a",     a0, 1'b1);
    chk("pre_rst_level", lvl0, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_abc",   {a0, b0, c0}, 3'b000);
    chk("mid_rst_act",   act0, 1'b0);
    chk("mid_rst_busy",  busy0, 1'b0);
    chk("mid_rst_level", lvl0, 3'd0);
    chk("mid_rst_ready", cif0.code_ready, 1'b1);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("post_rst%0d_abc", n),  {a0, b0, c0}, 3'b000);
      chk($sformatf("post_rst%0d_busy", n), busy0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
